mux_arbiter8: RTL and testbench



---
 rtl/mux_arbiter8_pkg.sv | 15 +
 rtl/mux_arbiter8_if.sv | 26 ++
 rtl/mux8x1_8b.sv | 22 ++
 rtl/mux_arbiter8_rr_pick8.sv | 32 +++
 rtl/mux_arbiter8.sv | 111 +++++++++++
 tb/tb_mux_arbiter8.sv | 157 +++++++++++++++
 6 files changed

// File: rtl/mux_arbiter8_pkg.sv
// rtl/mux_arbiter8_pkg.sv - shared state encodings and width constants
//   no ports; imported by the interface, rr_pick8 and mux_arbiter8
package mux_arbiter8_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int N_REQ  = 8;
   localparam int SEL_W  = 3;
   localparam int DATA_W = 8;
   localparam int BEAT_W = 4;

endpackage

// File: rtl/mux_arbiter8_if.sv
// rtl/mux_arbiter8_if.sv - requester/downstream bus of the 8:1 arbiter
//   req, d0..d7, out_ready : into the arbiter
//   out_valid, out_data, sel, gnt, ack : out of the arbiter
//   slave = arbiter side, master = requester/consumer side
interface mux_arbiter8_if;
   import mux_arbiter8_pkg::*;

   logic [N_REQ-1:0]  req;
   logic [DATA_W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  sel;
   logic [N_REQ-1:0]  gnt;
   logic [N_REQ-1:0]  ack;

   modport slave (
      input  req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
      output out_valid, out_data, sel, gnt, ack
   );

   modport master (
      output req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
      input  out_valid, out_data, sel, gnt, ack
   );
endinterface

// File: rtl/mux8x1_8b.sv
// rtl/mux8x1_8b.sv - 8-bit 8:1 data multiplexer
//   sel : word select; d0..d7 : data words; y : selected word
module MUX8x1_8B (
   input  logic [2:0] sel,
   input  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7,
   output logic [7:0] y
);
   always_comb begin
      y = d0;
      case (sel)
         3'd0: y = d0;
         3'd1: y = d1;
         3'd2: y = d2;
         3'd3: y = d3;
         3'd4: y = d4;
         3'd5: y = d5;
         3'd6: y = d6;
         3'd7: y = d7;
         default: y = d0;
      endcase
   end
endmodule

// File: rtl/mux_arbiter8_rr_pick8.sv
// rtl/mux_arbiter8_rr_pick8.sv - round-robin pick of the next requester
//   req : request vector; last : last served index
//   found : any request present; idx : first set bit after last, wrapping 7->0
module rr_pick8
   import mux_arbiter8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic             found,
   output logic [SEL_W-1:0] idx
);
   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   always_comb begin
      rot   = '0;
      off   = '0;
      found = 1'b0;
      // Rotate so bit 0 of rot is requester last+1; 3-bit index arithmetic wraps.
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[last + 3'd1 + SEL_W'(i)];
      end
      // Scan downwards so the lowest set bit wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = SEL_W'(i);
         end
      end
      idx = last + 3'd1 + off;
   end
endmodule

// File: rtl/mux_arbiter8.sv
// rtl/mux_arbiter8.sv - round-robin arbiter and sequencer for the 8:1 data mux
//   clk, rst : clock and synchronous active-high reset
//   bus      : requester/downstream bus (slave side)
//   BURST    : max accepted words per grant (1..15); PTR_INIT : reset last-served index
module mux_arbiter8
   import mux_arbiter8_pkg::*;
#(
   parameter int BURST    = 4,
   parameter int PTR_INIT = 7
) (
   input  logic           clk,
   input  logic           rst,
   mux_arbiter8_if.slave  bus
);
   localparam logic [BEAT_W-1:0] BURST_L = BEAT_W'(BURST);
   localparam logic [SEL_W-1:0]  LAST_INIT = SEL_W'(PTR_INIT);

   state_t            state_q, state_n;
   logic [SEL_W-1:0]  sel_q, sel_n;
   logic [N_REQ-1:0]  gnt_q, gnt_n;
   logic [BEAT_W-1:0] beat_q, beat_n;
   logic [SEL_W-1:0]  last_q, last_n;

   logic              found;
   logic [SEL_W-1:0]  pick_idx;
   logic              accept;
   logic [BEAT_W-1:0] beat_inc;

   rr_pick8 u_pick (
      .req   (bus.req),
      .last  (last_q),
      .found (found),
      .idx   (pick_idx)
   );

   MUX8x1_8B u_mux (
      .sel (sel_q),
      .d0  (bus.d0),
      .d1  (bus.d1),
      .d2  (bus.d2),
      .d3  (bus.d3),
      .d4  (bus.d4),
      .d5  (bus.d5),
      .d6  (bus.d6),
      .d7  (bus.d7),
      .y   (bus.out_data)
   );

   assign bus.out_valid = (state_q == ST_GRANT);
   assign bus.sel       = sel_q;
   assign bus.gnt       = gnt_q;

   // A word is taken only while the granted requester still asserts req;
   // reset suppresses the ack so nothing is consumed in the reset cycle.
   assign accept   = bus.out_valid & bus.out_ready & bus.req[sel_q] & ~rst;
   assign bus.ack  = gnt_q & {N_REQ{accept}};
   assign beat_inc = beat_q + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         beat_q  <= '0;
         last_q  <= LAST_INIT;
      end else begin
         state_q <= state_n;
         sel_q   <= sel_n;
         gnt_q   <= gnt_n;
         beat_q  <= beat_n;
         last_q  <= last_n;
      end
   end

   always_comb begin
      state_n = state_q;
      sel_n   = sel_q;
      gnt_n   = gnt_q;
      beat_n  = beat_q;
      last_n  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_n = ST_GRANT;
               sel_n   = pick_idx;
               gnt_n   = N_REQ'(1) << pick_idx;
               beat_n  = '0;
            end
         end
         ST_GRANT: begin
            if (!bus.req[sel_q]) begin
               // Abort: the pointer still advances past the aborted requester.
               state_n = ST_IDLE;
               gnt_n   = '0;
               last_n  = sel_q;
            end else if (bus.out_ready) begin
               beat_n = beat_inc;
               if (beat_inc == BURST_L) begin
                  state_n = ST_IDLE;
                  gnt_n   = '0;
                  last_n  = sel_q;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            gnt_n   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_mux_arbiter8.sv
// tb/tb_mux_arbiter8.sv - directed self-checking bench for mux_arbiter8
module tb_mux_arbiter8;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mux_arbiter8_if bus4 ();
   mux_arbiter8_if bus1 ();

   mux_arbiter8 #(.BURST(4), .PTR_INIT(7)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   mux_arbiter8 #(.BURST(1), .PTR_INIT(7)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus4.req = '0; bus4.out_ready = 1'b0;
      bus1.req = '0; bus1.out_ready = 1'b0;
      bus4.d0 = 8'h10; bus4.d1 = 8'h11; bus4.d2 = 8'h12; bus4.d3 = 8'h13;
      bus4.d4 = 8'h14; bus4.d5 = 8'h15; bus4.d6 = 8'h16; bus4.d7 = 8'h17;
      bus1.d0 = 8'hC0; bus1.d1 = 8'hC1; bus1.d2 = 8'hC2; bus1.d3 = 8'hC3;
      bus1.d4 = 8'hC4; bus1.d5 = 8'hC5; bus1.d6 = 8'hC6; bus1.d7 = 8'hC7;
      tick();
      tick();

      chk("rst_out_valid", 8'(bus4.out_valid), 8'h00);
      chk("rst_gnt",       bus4.gnt,           8'h00);
      chk("rst_sel",       8'(bus4.sel),       8'h00);
      chk("rst_ack",       bus4.ack,           8'h00);
      rst = 1'b0;

      // Single requester, full burst of 4, bubble, regrant.
      bus4.req = 8'h04; bus4.d2 = 8'hA5; bus4.out_ready = 1'b1;
      #1;
      chk("t1_idle_valid", 8'(bus4.out_valid), 8'h00);
      tick();
      for (int b = 0; b < 4; b++) begin
         bus4.d2 = 8'hA5 + 8'(b);
         #1;
         chk("t1_sel",  8'(bus4.sel),  8'h02);
         chk("t1_gnt",  bus4.gnt,      8'h04);
         chk("t1_data", bus4.out_data, 8'hA5 + 8'(b));
         chk("t1_ack",  bus4.ack,      8'h04);
         tick();
      end
      chk("t1_bubble_valid", 8'(bus4.out_valid), 8'h00);
      chk("t1_bubble_gnt",   bus4.gnt,           8'h00);
      chk("t1_bubble_ack",   bus4.ack,           8'h00);
      tick();
      chk("t1_regrant_sel", 8'(bus4.sel), 8'h02);
      chk("t1_regrant_gnt", bus4.gnt,     8'h04);
      bus4.req = 8'h00;
      #1;
      chk("t1_drop_ack", bus4.ack, 8'h00);
      tick();

      // Backpressure on requester 5.
      bus4.req = 8'h20; bus4.d5 = 8'h5A; bus4.out_ready = 1'b0;
      tick();
      for (int c = 0; c < 6; c++) begin
         chk("bp_valid", 8'(bus4.out_valid), 8'h01);
         chk("bp_sel",   8'(bus4.sel),       8'h05);
         chk("bp_data",  bus4.out_data,      8'h5A);
         chk("bp_ack",   bus4.ack,           8'h00);
         tick();
      end
      bus4.out_ready = 1'b1;
      #1;
      chk("bp_release_ack", bus4.ack, 8'h20);
      tick();
      bus4.out_ready = 1'b0;
      #1;
      chk("bp_single_ack", bus4.ack, 8'h00);
      bus4.req = 8'h00;
      tick();

      // Abort on requester 3; next search starts at 4.
      bus4.req = 8'h08;
      tick();
      chk("ab_sel", 8'(bus4.sel), 8'h03);
      bus4.req = 8'h00; bus4.out_ready = 1'b1;
      #1;
      chk("ab_ack", bus4.ack, 8'h00);
      tick();
      chk("ab_idle_valid", 8'(bus4.out_valid), 8'h00);
      bus4.req = 8'h19; bus4.out_ready = 1'b0;
      tick();
      chk("ab_next_sel", 8'(bus4.sel), 8'h04);
      chk("ab_next_gnt", bus4.gnt,     8'h10);
      bus4.req = 8'h00;
      tick();

      // Reset during the second beat of a grant to requester 6.
      bus4.req = 8'h40; bus4.d6 = 8'h66; bus4.out_ready = 1'b1;
      tick();
      chk("rm_first_ack", bus4.ack, 8'h40);
      tick();
      chk("rm_second_sel", 8'(bus4.sel), 8'h06);
      rst = 1'b1;
      #1;
      chk("rm_rst_ack", bus4.ack, 8'h00);
      tick();
      chk("rm_valid", 8'(bus4.out_valid), 8'h00);
      chk("rm_gnt",   bus4.gnt,           8'h00);
      chk("rm_sel",   8'(bus4.sel),       8'h00);
      rst = 1'b0;
      bus4.req = 8'hFF;
      tick();
      chk("rm_regrant_gnt", bus4.gnt, 8'h01);
      bus4.req = 8'h00;
      tick();

      // Round-robin with BURST=1: 0..7,0 with one bubble between grants.
      bus1.req = 8'hFF; bus1.out_ready = 1'b1;
      tick();
      for (int k = 0; k < 9; k++) begin
         chk("rr_sel",  8'(bus1.sel),  8'(k % 8));
         chk("rr_gnt",  bus1.gnt,      8'h01 << (k % 8));
         chk("rr_data", bus1.out_data, 8'hC0 + 8'(k % 8));
         chk("rr_ack",  bus1.ack,      8'h01 << (k % 8));
         tick();
         chk("rr_bubble", 8'(bus1.out_valid), 8'h00);
         tick();
      end
      bus1.req = 8'h00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
